// File: rtl/pcm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pcm_pkg
// Purpose  : Shared PCM definitions: sample width, saturation helper and the
//            DC-blocker control FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package pcm_pkg;

    localparam int PCM_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } pcm_state_e;

    // Clamp a PCM_W+2 wide signed value into the PCM_W signed range.
    // In range exactly when the top three bits agree.
    function automatic logic signed [PCM_W-1:0] sat_pcm(input logic signed [PCM_W+1:0] d);
        if ((d[PCM_W+1:PCM_W-1] == 3'b000) || (d[PCM_W+1:PCM_W-1] == 3'b111)) begin
            sat_pcm = d[PCM_W-1:0];
        end else if (d[PCM_W+1]) begin
            sat_pcm = {1'b1, {(PCM_W-1){1'b0}}};
        end else begin
            sat_pcm = {1'b0, {(PCM_W-1){1'b1}}};
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO, registered write, first-word-fall-through
//            read. A pop on an empty FIFO is ignored; a push on a full FIFO
//            is accepted only when a pop frees the slot in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    LVL_FULL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       level_q;
    logic              pop_ok;
    logic              push_ok;

    assign full_o  = (level_q == LVL_FULL);
    assign empty_o = (level_q == '0);
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign data_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Storage array: written at the write pointer on an accepted push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); level tracks occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pcm_dc_block_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pcm_dc_block_fifo
// Purpose  : Captures decimator PCM samples on the synchronised pcm_clk rise,
//            removes DC with a one-pole high-pass filter and buffers the
//            results in a FWFT FIFO behind a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module pcm_dc_block_fifo
    import pcm_pkg::*;
#(
    parameter int DATA_W      = PCM_W,
    parameter int DC_SHIFT    = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          pcm_clk_in,
    input  logic [DATA_W-1:0]             pcm_in,
    input  logic                          enable,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clear_overflow
);
    logic [SYNC_STAGES-1:0]      sync_q;
    logic                        edge_q;
    logic                        cap_pulse;
    logic                        cap_dly_q;
    logic signed [DATA_W-1:0]    x_cur_q;
    logic signed [DATA_W-1:0]    x_prev_q;
    logic signed [DATA_W-1:0]    y_prev_q;
    logic signed [DATA_W-1:0]    y_q;
    logic                        push_q;
    logic                        overflow_q;
    pcm_state_e                  state_q;
    pcm_state_e                  state_d;

    logic signed [DATA_W+1:0]    x_cur_s;
    logic signed [DATA_W+1:0]    x_prev_s;
    logic signed [DATA_W+1:0]    y_prev_s;
    logic signed [DATA_W+1:0]    d_s;
    logic signed [DATA_W-1:0]    y_sat;
    logic                        push;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        drop;

    // Synchroniser chain plus edge flop for the slow sample strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pcm_clk_in};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign cap_pulse = sync_q[SYNC_STAGES-1] & ~edge_q;

    // Sample capture; the decimator holds pcm_in stable around the rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_cur_q   <= '0;
            cap_dly_q <= 1'b0;
        end else begin
            cap_dly_q <= cap_pulse;
            if (cap_pulse) x_cur_q <= pcm_in;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next state: prime on the first captured sample, then run.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = PRIME;
            PRIME:   if (cap_dly_q) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (!enable) state_d = IDLE;
    end

    // High-pass filter arithmetic, two guard bits to hold the full range.
    assign x_cur_s  = {{2{x_cur_q[DATA_W-1]}},  x_cur_q};
    assign x_prev_s = {{2{x_prev_q[DATA_W-1]}}, x_prev_q};
    assign y_prev_s = {{2{y_prev_q[DATA_W-1]}}, y_prev_q};
    assign d_s      = x_cur_s - x_prev_s + y_prev_s - (y_prev_s >>> DC_SHIFT);
    assign y_sat    = sat_pcm(d_s);

    // Filter state and result register; disabling clears state and kills
    // any result waiting to be pushed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_prev_q <= '0;
            y_prev_q <= '0;
            y_q      <= '0;
            push_q   <= 1'b0;
        end else if (!enable) begin
            x_prev_q <= '0;
            y_prev_q <= '0;
            push_q   <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (cap_dly_q) begin
                case (state_q)
                    PRIME: begin
                        x_prev_q <= x_cur_q;
                        y_prev_q <= '0;
                    end
                    RUN: begin
                        x_prev_q <= x_cur_q;
                        y_prev_q <= y_sat;
                        y_q      <= y_sat;
                        push_q   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign push = push_q & enable;
    assign drop = push & fifo_full & ~(out_valid & out_ready);

    // Sticky overflow; a clear takes priority over a same-cycle drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            overflow_q <= 1'b0;
        else if (clear_overflow) overflow_q <= 1'b0;
        else if (drop)           overflow_q <= 1'b1;
    end

    assign overflow  = overflow_q;
    assign out_valid = ~fifo_empty;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .data_i  (y_q),
        .pop_i   (out_ready),
        .data_o  (out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

endmodule
`default_nettype wire

// File: tb/tb_pcm_dc_block_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pcm_dc_block_fifo
// Purpose  : Directed self-checking bench for pcm_dc_block_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcm_dc_block_fifo;

    logic        clk;
    logic        reset_n;
    logic        pcm_clk_in;
    logic [15:0] pcm_in;
    logic        enable;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        clear_overflow;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        v_before;
    logic        v_after;

    pcm_dc_block_fifo #(
        .DATA_W      (16),
        .DC_SHIFT    (8),
        .FIFO_DEPTH  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pcm_clk_in     (pcm_clk_in),
        .pcm_in         (pcm_in),
        .enable         (enable),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One pcm_clk period. The push edge is the 5th rising clk edge after the
    // strobe is driven (2 sync flops, capture, compute, write); rdy/clr are
    // applied exactly on that edge. v_before/v_after bracket it.
    task automatic send(input logic [15:0] v, input bit rdy, input bit clr);
        @(negedge clk);
        pcm_in     = v;
        pcm_clk_in = 1'b1;
        repeat (4) @(negedge clk);
        v_before       = out_valid;
        out_ready      = rdy;
        clear_overflow = clr;
        @(negedge clk);
        v_after        = out_valid;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
        repeat (27) @(negedge clk);
        pcm_clk_in = 1'b0;
        repeat (32) @(negedge clk);
    endtask

    task automatic pop_expect(input string tag, input logic [15:0] exp);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check(tag, 32'(out_data), 32'(exp));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic toggle_enable();
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n        = 1'b0;
        pcm_clk_in     = 1'b0;
        pcm_in         = '0;
        enable         = 1'b0;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_valid", 32'(out_valid),  32'd0);
        check("rst_data",  32'(out_data),   32'd0);
        check("rst_ovf",   32'(overflow),   32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);

        // Step response with latency measurement.
        send(16'd0, 0, 0);
        check("prime_no_push", 32'(fifo_level), 32'd0);
        send(16'd1000, 0, 0);
        check("lat_before", 32'(v_before), 32'd0);
        check("lat_exact",  32'(v_after),  32'd1);
        send(16'd1000, 0, 0);
        send(16'd1000, 0, 0);
        check("step_level", 32'(fifo_level), 32'd3);
        pop_expect("step0", 16'd1000);
        pop_expect("step1", 16'd997);
        pop_expect("step2", 16'd994);

        // Saturation: 32767 - (-32768) clamps to +32767.
        toggle_enable();
        send(16'h8000, 0, 0);
        check("sat_prime", 32'(fifo_level), 32'd0);
        send(16'h7FFF, 0, 0);
        check("no_x", 32'($isunknown({out_data, out_valid, fifo_level, overflow})), 32'd0);
        pop_expect("sat", 16'h7FFF);

        // Enable toggle: prior FIFO content survives, filter re-primes.
        send(16'h7FFF, 0, 0);
        check("tog_pre_level", 32'(fifo_level), 32'd1);
        toggle_enable();
        send(16'd500, 0, 0);
        check("tog_prime_level", 32'(fifo_level), 32'd1);
        send(16'd500, 0, 0);
        check("tog_level", 32'(fifo_level), 32'd2);
        pop_expect("tog_kept", 16'h7F80);
        pop_expect("tog_zero", 16'd0);

        // Overflow: ramp input gives y == sample index while y < 256.
        toggle_enable();
        send(16'd0, 0, 0);
        for (int k = 1; k <= 16; k++) send(16'(k), 0, 0);
        check("full_level", 32'(fifo_level), 32'd16);
        check("full_ovf",   32'(overflow),   32'd0);
        send(16'd17, 0, 0);
        check("ovf_set",    32'(overflow),   32'd1);
        check("ovf_level",  32'(fifo_level), 32'd16);
        send(16'd18, 0, 0);
        check("ovf_level2", 32'(fifo_level), 32'd16);
        for (int k = 1; k <= 16; k++) pop_expect($sformatf("ovf_order%0d", k), 16'(k));
        check("drain_level", 32'(fifo_level), 32'd0);

        // Full FIFO with simultaneous push/pop, then clear-vs-drop priority.
        @(negedge clk);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        for (int k = 19; k <= 34; k++) send(16'(k), 0, 0);
        check("full2_level", 32'(fifo_level), 32'd16);
        send(16'd35, 1, 0);
        check("pushpop_level", 32'(fifo_level), 32'd16);
        check("pushpop_ovf",   32'(overflow),   32'd0);
        check("pushpop_head",  32'(out_data),   32'd20);
        send(16'd36, 0, 1);
        check("clr_wins", 32'(overflow), 32'd0);
        send(16'd37, 0, 0);
        check("ovf_again", 32'(overflow), 32'd1);
        for (int k = 20; k <= 35; k++) pop_expect($sformatf("full_order%0d", k), 16'(k));
        check("empty_level", 32'(fifo_level), 32'd0);
        check("empty_valid", 32'(out_valid),  32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_ready_level", 32'(fifo_level), 32'd0);
        send(16'd38, 1, 0);
        check("empty_pushpop", 32'(fifo_level), 32'd1);
        check("empty_pushpop_data", 32'(out_data), 32'd38);
        for (int k = 39; k <= 42; k++) send(16'(k), 0, 0);
        check("pre_rst_level", 32'(fifo_level), 32'd5);
        check("pre_rst_ovf",   32'(overflow),   32'd1);

        // Reset mid-run.
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_level", 32'(fifo_level), 32'd0);
        check("midrst_valid", 32'(out_valid),  32'd0);
        check("midrst_ovf",   32'(overflow),   32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
